// File: rtl/scan_code_pkg.sv
// scan_code_pkg: FSM states, set-2 scan constants and the 512x8 scan-to-ASCII table
package scan_code_pkg;
    localparam int ADDR_W = 9;
    typedef enum logic [1:0] {IDLE, LOOKUP, OUTPUT} state_e;
    localparam logic [7:0] SC_E0 = 8'hE0, SC_E1 = 8'hE1, SC_F0 = 8'hF0, SC_AA = 8'hAA;
    localparam logic [7:0] SC_SHIFT_L = 8'h12, SC_SHIFT_R = 8'h59, SC_CTRL = 8'h14, SC_CAPS = 8'h58;

    // Address is {ext, shift, code[6:0]}; letters stay lowercase in both halves
    function automatic logic [7:0] rom_entry(input logic [ADDR_W-1:0] a);
        logic sh;
        logic [7:0] r;
        sh = a[7];
        r = 8'h00;
        if (a[8]) r = a[6:0] == 7'h4A ? "/" : a[6:0] == 7'h5A ? 8'h0D : 8'h00;
        else case (a[6:0])
            7'h1C: r = "a";
            7'h32: r = "b";
            7'h21: r = "c";
            7'h23: r = "d";
            7'h24: r = "e";
            7'h2B: r = "f";
            7'h34: r = "g";
            7'h33: r = "h";
            7'h43: r = "i";
            7'h3B: r = "j";
            7'h42: r = "k";
            7'h4B: r = "l";
            7'h3A: r = "m";
            7'h31: r = "n";
            7'h44: r = "o";
            7'h4D: r = "p";
            7'h15: r = "q";
            7'h2D: r = "r";
            7'h1B: r = "s";
            7'h2C: r = "t";
            7'h3C: r = "u";
            7'h2A: r = "v";
            7'h1D: r = "w";
            7'h22: r = "x";
            7'h35: r = "y";
            7'h1A: r = "z";
            7'h45: r = sh ? ")" : "0";
            7'h16: r = sh ? "!" : "1";
            7'h1E: r = sh ? "@" : "2";
            7'h26: r = sh ? "#" : "3";
            7'h25: r = sh ? "$" : "4";
            7'h2E: r = sh ? "%" : "5";
            7'h36: r = sh ? "^" : "6";
            7'h3D: r = sh ? "&" : "7";
            7'h3E: r = sh ? "*" : "8";
            7'h46: r = sh ? "(" : "9";
            7'h0E: r = sh ? "~" : 8'h60;
            7'h4E: r = sh ? "_" : "-";
            7'h55: r = sh ? "+" : "=";
            7'h5D: r = sh ? "|" : "\\";
            7'h54: r = sh ? "{" : "[";
            7'h5B: r = sh ? "}" : "]";
            7'h4C: r = sh ? ":" : ";";
            7'h52: r = sh ? "\"" : "'";
            7'h41: r = sh ? "<" : ",";
            7'h49: r = sh ? ">" : ".";
            7'h4A: r = sh ? "?" : "/";
            7'h5A: r = 8'h0D;
            7'h66: r = 8'h08;
            7'h76: r = 8'h1B;
            7'h0D: r = 8'h09;
            7'h29: r = 8'h20;
            default: r = 8'h00;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/scan_code_rom.sv
// scan_code_rom: synchronous 512x8 ROM built from the package table
module scan_code_rom
    import scan_code_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_q
);
    always_ff @(posedge clk) data_q <= rom_entry(addr);
endmodule

// File: rtl/scan_code_decoder.sv
// scan_code_decoder: PS/2 set-2 scan bytes to ASCII with prefix, modifier and caps-lock tracking
module scan_code_decoder
    import scan_code_pkg::*;
#(
    parameter bit CTRL_CODES = 1'b1,
    parameter int PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       reset,
    output logic       scan_code_ready,
    input  logic       scan_code_valid,
    input  logic [7:0] scan_code_byte,
    input  logic       character_ready,
    output logic       character_valid,
    output logic [7:0] character_byte,
    output logic       caps_lock
);
    localparam int SW = $clog2(PAUSE_SKIP + 1);
    state_e state_q, state_d;
    logic [SW-1:0] skip_q, skip_d;
    logic ext_q, ext_d, brk_q, brk_d, shl_q, shl_d, shr_q, shr_d, ctl_q, ctl_d, ctr_q, ctr_d;
    logic caps_q, caps_d, held_q, held_d, valid_q, valid_d;
    logic [7:0] char_q, char_d, rom_data;
    logic shift, ctrl, letter;

    assign shift = shl_q | shr_q;
    assign ctrl = ctl_q | ctr_q;
    assign letter = rom_data >= "a" && rom_data <= "z";
    assign scan_code_ready = state_q == IDLE;
    assign character_valid = valid_q;
    assign character_byte = char_q;
    assign caps_lock = caps_q;

    // ROM registers the address presented during the accepting IDLE cycle
    scan_code_rom u_rom (.clk(clk), .addr({ext_q, shift, scan_code_byte[6:0]}), .data_q(rom_data));

    always_comb begin
        state_d = state_q;
        skip_d = skip_q;
        ext_d = ext_q;
        brk_d = brk_q;
        shl_d = shl_q;
        shr_d = shr_q;
        ctl_d = ctl_q;
        ctr_d = ctr_q;
        caps_d = caps_q;
        held_d = held_q;
        valid_d = valid_q;
        char_d = char_q;
        if (state_q == IDLE && scan_code_valid) begin
            if (skip_q != '0) skip_d = skip_q - SW'(1);
            else if (scan_code_byte == SC_E1) skip_d = SW'(PAUSE_SKIP);
            else if (scan_code_byte == SC_E0) ext_d = 1'b1;
            else if (scan_code_byte == SC_F0) brk_d = 1'b1;
            else if (scan_code_byte inside {8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE}) skip_d = skip_q;
            else if (scan_code_byte == SC_AA) begin
                {ext_d, brk_d, shl_d, shr_d, ctl_d, ctr_d, caps_d, held_d} = '0;
            end else if (scan_code_byte[7] || scan_code_byte inside {SC_SHIFT_L, SC_SHIFT_R, SC_CTRL, SC_CAPS}) begin
                // Modifiers and non-ASCII codes end any prefix; E0 12/E0 59 fall through untouched
                ext_d = 1'b0;
                brk_d = 1'b0;
                shl_d = scan_code_byte == SC_SHIFT_L && !ext_q ? !brk_q : shl_q;
                shr_d = scan_code_byte == SC_SHIFT_R && !ext_q ? !brk_q : shr_q;
                ctl_d = scan_code_byte == SC_CTRL && !ext_q ? !brk_q : ctl_q;
                ctr_d = scan_code_byte == SC_CTRL && ext_q ? !brk_q : ctr_q;
                if (scan_code_byte == SC_CAPS && !ext_q) begin
                    caps_d = caps_q ^ (!brk_q && !held_q);
                    held_d = !brk_q;
                end
            end else state_d = LOOKUP;
        end else if (state_q == LOOKUP) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (brk_q || rom_data == 8'h00) state_d = IDLE;
            else begin
                state_d = OUTPUT;
                valid_d = 1'b1;
                char_d = letter && ctrl && CTRL_CODES ? rom_data & 8'h1F :
                         letter && (shift ^ caps_q) ? rom_data & 8'hDF : rom_data;
            end
        end else if (state_q == OUTPUT && character_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            skip_q <= '0;
            {ext_q, brk_q, shl_q, shr_q, ctl_q, ctr_q, caps_q, held_q, valid_q} <= '0;
            char_q <= 8'h00;
        end else begin
            state_q <= state_d;
            skip_q <= skip_d;
            {ext_q, brk_q, shl_q, shr_q, ctl_q, ctr_q, caps_q, held_q, valid_q} <=
                {ext_d, brk_d, shl_d, shr_d, ctl_d, ctr_d, caps_d, held_d, valid_d};
            char_q <= char_d;
        end
    end
endmodule

// File: tb/tb_scan_code_decoder.sv
// tb_scan_code_decoder: directed scenarios for the scan-code to ASCII decoder
module tb_scan_code_decoder;
    logic clk = 1'b0, reset = 1'b1, scan_code_valid = 1'b0, character_ready = 1'b1;
    logic scan_code_ready, character_valid, caps_lock;
    logic [7:0] scan_code_byte = 8'h00, character_byte;
    logic [7:0] q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    scan_code_decoder dut (
        .clk(clk), .reset(reset),
        .scan_code_ready(scan_code_ready), .scan_code_valid(scan_code_valid), .scan_code_byte(scan_code_byte),
        .character_ready(character_ready), .character_valid(character_valid), .character_byte(character_byte),
        .caps_lock(caps_lock)
    );

    always @(negedge clk) if (!reset && character_valid && character_ready) q.push_back(character_byte);

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!scan_code_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!scan_code_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%b for byte %h, required 1", scan_code_ready, b);
        end
        scan_code_valid = 1'b1;
        scan_code_byte = b;
        @(posedge clk); #1;
        scan_code_valid = 1'b0;
    endtask

    task automatic settle;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (scan_code_ready !== 1'b1 || character_valid !== 1'b0 || character_byte !== 8'h00 || caps_lock !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b byte=%h caps=%b, required 1 0 00 0",
                     scan_code_ready, character_valid, character_byte, caps_lock);
        end
        reset = 1'b0;
    endtask

    task automatic test_latency;
        q.delete();
        send(8'h1C);
        checks++;
        if (character_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_n1: valid=%b, required 0", character_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (character_valid !== 1'b1 || character_byte !== 8'h61) begin
            errors++;
            $display("FAIL latency_n2: valid=%b byte=%h, required 1 61", character_valid, character_byte);
        end
        settle();
        checks++;
        if (q.size() !== 1 || q[0] !== 8'h61) begin
            errors++;
            $display("FAIL latency_out: got %p, required 61", q);
        end
    endtask

    task automatic test_make_break;
        q.delete();
        send(8'h1C); send(8'hF0); send(8'h1C);
        settle();
        checks++;
        if (q.size() !== 1 || q[0] !== 8'h61) begin
            errors++;
            $display("FAIL make_break: got %p, required 61", q);
        end
    endtask

    task automatic test_shift;
        q.delete();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        send(8'h59); send(8'h16); send(8'hF0); send(8'h59);
        settle();
        checks++;
        if (q.size() !== 3 || q[0] !== 8'h41 || q[1] !== 8'h61 || q[2] !== 8'h21) begin
            errors++;
            $display("FAIL shift: got %p, required 41 61 21", q);
        end
    endtask

    task automatic test_caps;
        q.delete();
        send(8'h58); send(8'hF0); send(8'h58);
        settle();
        checks++;
        if (caps_lock !== 1'b1) begin
            errors++;
            $display("FAIL caps_on: caps=%b, required 1", caps_lock);
        end
        send(8'h1C); send(8'h16);
        settle();
        checks++;
        if (q.size() !== 2 || q[0] !== 8'h41 || q[1] !== 8'h31) begin
            errors++;
            $display("FAIL caps_chars: got %p, required 41 31", q);
        end
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        settle();
        checks++;
        if (caps_lock !== 1'b0) begin
            errors++;
            $display("FAIL caps_repeat: caps=%b, required 0", caps_lock);
        end
    endtask

    task automatic test_ctrl;
        q.delete();
        send(8'h14); send(8'h21); send(8'hF0); send(8'h14);
        send(8'hE0); send(8'h14); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h14);
        send(8'h1C);
        settle();
        checks++;
        if (q.size() !== 3 || q[0] !== 8'h03 || q[1] !== 8'h01 || q[2] !== 8'h61) begin
            errors++;
            $display("FAIL ctrl: got %p, required 03 01 61", q);
        end
    endtask

    task automatic test_fixed_and_ext;
        q.delete();
        send(8'h5A); send(8'h66); send(8'h29); send(8'hE0); send(8'h4A); send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'h75); send(8'h12); send(8'h4A); send(8'hF0); send(8'h12);
        settle();
        checks++;
        if (q.size() !== 6 || q[0] !== 8'h0D || q[1] !== 8'h08 || q[2] !== 8'h20 || q[3] !== 8'h2F ||
            q[4] !== 8'h0D || q[5] !== 8'h3F) begin
            errors++;
            $display("FAIL fixed_ext: got %p, required 0d 08 20 2f 0d 3f", q);
        end
    endtask

    task automatic test_backpressure;
        character_ready = 1'b0;
        q.delete();
        send(8'h1C);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (character_valid !== 1'b1 || character_byte !== 8'h61 || scan_code_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b byte=%h ready=%b, required 1 61 0",
                         i, character_valid, character_byte, scan_code_ready);
            end
            @(posedge clk); #1;
        end
        character_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (character_valid !== 1'b0 || scan_code_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: valid=%b ready=%b, required 0 1", character_valid, scan_code_ready);
        end
        settle();
        checks++;
        if (q.size() !== 1 || q[0] !== 8'h61) begin
            errors++;
            $display("FAIL backpressure_out: got %p, required 61", q);
        end
    endtask

    task automatic test_pause;
        q.delete();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        settle();
        checks++;
        if (q.size() !== 1 || q[0] !== 8'h61) begin
            errors++;
            $display("FAIL pause: got %p, required 61", q);
        end
    endtask

    task automatic test_self_test;
        q.delete();
        send(8'h12); send(8'h58); send(8'hF0); send(8'h58); send(8'hAA); send(8'h1C); send(8'h16);
        settle();
        checks++;
        if (q.size() !== 2 || q[0] !== 8'h61 || q[1] !== 8'h31 || caps_lock !== 1'b0) begin
            errors++;
            $display("FAIL self_test: got %p caps=%b, required 61 31 caps 0", q, caps_lock);
        end
    endtask

    task automatic test_reset_in_output;
        send(8'h58); send(8'hF0); send(8'h58);
        settle();
        character_ready = 1'b0;
        send(8'h1C);
        @(posedge clk); #1;
        checks++;
        if (character_valid !== 1'b1 || caps_lock !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b caps=%b, required 1 1", character_valid, caps_lock);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (character_valid !== 1'b0 || caps_lock !== 1'b0 || scan_code_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: valid=%b caps=%b ready=%b, required 0 0 1",
                     character_valid, caps_lock, scan_code_ready);
        end
        reset = 1'b0;
        character_ready = 1'b1;
        q.delete();
        send(8'h1C);
        settle();
        checks++;
        if (q.size() !== 1 || q[0] !== 8'h61) begin
            errors++;
            $display("FAIL post_reset: got %p, required 61", q);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_make_break();
        test_shift();
        test_caps();
        test_ctrl();
        test_fixed_and_ext();
        test_backpressure();
        test_pause();
        test_self_test();
        test_reset_in_output();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
